// File: rtl/unary_stream_decoder_pkg.sv
// Shared types and helpers for the unary stream decoder: controller states,
// frame-length/count-width helpers and the sign-magnitude to two's-complement conversion.
package unary_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int frame_len(input int size);
        return 1 << size;
    endfunction

    // A full window of ones reaches W, so the count needs one bit above the magnitude.
    function automatic int cnt_width(input int size);
        return size + 1;
    endfunction

    // Result is 32 bits wide; callers cast it down to their word width, which keeps the
    // two's-complement pattern intact. A saturated count clamps the magnitude to W-1,
    // and a zero magnitude stays 0 whatever the sign.
    function automatic logic [31:0] sm_to_twos(input logic sign, input logic [31:0] mag,
                                               input logic sat, input int size);
        logic [31:0] m;
        m = sat ? ((32'd1 << size) - 32'd1) : mag;
        return sign ? (32'd0 - m) : m;
    endfunction

endpackage

// File: rtl/unary_stream_decoder_if.sv
// Stream-side bundle of the unary decoder: frame/sample inputs and the result handshake.
interface unary_stream_decoder_if #(
    parameter int LANES     = 2,
    parameter int BIT_WIDTH = 4
);
    logic                         frame_start;
    logic [LANES-1:0]             unary_in;
    logic [LANES-1:0]             sign_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*BIT_WIDTH-1:0]   out_data;
    logic [LANES-1:0]             overflow;
    logic                         frame_drop;

    modport master (
        output frame_start, unary_in, sign_in, out_ready,
        input  out_valid, out_data, overflow, frame_drop
    );

    modport slave (
        input  frame_start, unary_in, sign_in, out_ready,
        output out_valid, out_data, overflow, frame_drop
    );
endinterface

// File: rtl/unary_stream_decoder_lane_counter.sv
// One lane of the decoder: counts 1s over a frame (load on sample 0, then accumulate),
// saturating at W, and latches the lane sign on the load cycle.
module unary_lane_counter
    import unary_dec_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic          unary_bit,
    input  logic          sign_bit,
    output logic [SIZE:0] count_nxt,
    output logic          sign_q
);
    localparam int W     = frame_len(SIZE);
    localparam int CNT_W = cnt_width(SIZE);

    logic [CNT_W-1:0] count_q;

    // count_nxt already includes this cycle's sample, so the controller can capture
    // the finished count on the edge that ends the last sample.
    always_comb begin
        count_nxt = count_q;
        if (load) begin
            count_nxt = CNT_W'(unary_bit);
        end else if (en && (count_q != CNT_W'(W))) begin
            count_nxt = count_q + CNT_W'(unary_bit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            if (load) begin
                sign_q <= sign_bit;
            end
        end
    end

endmodule

// File: rtl/unary_stream_decoder.sv
// Unary-to-binary stream decoder: decodes per-lane unary frames of 2^SIZE cycles into
// signed words behind a valid/ready register. Define UNARY_DEC_DOUBLE_BUF_EN for a second result slot.
module unary_stream_decoder
    import unary_dec_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int SIZE      = BIT_WIDTH - 1,
    parameter int LANES     = 2
) (
    input logic                   clk,
    input logic                   reset,
    unary_stream_decoder_if.slave bus
);
    localparam int W     = frame_len(SIZE);
    localparam int CNT_W = cnt_width(SIZE);
    localparam int DW    = LANES * BIT_WIDTH;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   samp_q;
    logic              load, en, done, last, pop, drop_d;
    logic [DW-1:0]     res_data;
    logic [LANES-1:0]  res_ovf;
    logic              out_valid_q;
    logic [DW-1:0]     out_data_q;
    logic [LANES-1:0]  overflow_q;
    logic              frame_drop_q;

`ifdef UNARY_DEC_DOUBLE_BUF_EN
    logic              buf_vld_q;
    logic [DW-1:0]     buf_data_q;
    logic [LANES-1:0]  buf_ovf_q;
    logic              discard;
`endif

    // Sample counter runs 1..W-1 during ACCUM; all-ones marks the last sample.
    assign last = &samp_q;
    assign pop  = out_valid_q & bus.out_ready;

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        logic [CNT_W-1:0]            cnt_nxt;
        logic                        sgn;
        logic signed [BIT_WIDTH-1:0] word;

        unary_lane_counter #(.SIZE(SIZE)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .en        (en),
            .unary_bit (bus.unary_in[l]),
            .sign_bit  (bus.sign_in[l]),
            .count_nxt (cnt_nxt),
            .sign_q    (sgn)
        );

        assign res_ovf[l] = (cnt_nxt == CNT_W'(W));
        assign word = $signed(BIT_WIDTH'(sm_to_twos(sgn, 32'(cnt_nxt), res_ovf[l], SIZE)));
        assign res_data[l*BIT_WIDTH +: BIT_WIDTH] = word;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        en      = 1'b0;
        done    = 1'b0;
        drop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    load    = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                en     = 1'b1;
                drop_d = bus.frame_start;
                if (last) begin
                    done    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
`ifdef UNARY_DEC_DOUBLE_BUF_EN
                // The accumulator is free here; the result slots absorb the backlog.
                if (bus.frame_start) begin
                    load    = 1'b1;
                    state_d = ACCUM;
                end else if (pop && !buf_vld_q) begin
                    state_d = IDLE;
                end
`else
                if (pop) begin
                    if (bus.frame_start) begin
                        load    = 1'b1;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    drop_d = bus.frame_start;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            samp_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                samp_q <= SIZE'(1);
            end else if (en) begin
                samp_q <= samp_q + 1'b1;
            end
        end
    end

`ifdef UNARY_DEC_DOUBLE_BUF_EN
    assign discard = done && out_valid_q && buf_vld_q && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            overflow_q   <= '0;
            frame_drop_q <= 1'b0;
            buf_vld_q    <= 1'b0;
            buf_data_q   <= '0;
            buf_ovf_q    <= '0;
        end else begin
            frame_drop_q <= drop_d | discard;
            if (pop) begin
                if (buf_vld_q) begin
                    out_data_q <= buf_data_q;
                    overflow_q <= buf_ovf_q;
                    buf_vld_q  <= 1'b0;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            // A finished window goes to the oldest free slot after this cycle's pop.
            if (done) begin
                if (!out_valid_q || (pop && !buf_vld_q)) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= res_data;
                    overflow_q  <= res_ovf;
                end else if (!buf_vld_q || pop) begin
                    buf_vld_q  <= 1'b1;
                    buf_data_q <= res_data;
                    buf_ovf_q  <= res_ovf;
                end
            end
        end
    end
`else
    // out_valid is always low during ACCUM, so done and pop never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            overflow_q   <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= drop_d;
            if (done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_data;
                overflow_q  <= res_ovf;
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.frame_drop = frame_drop_q;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Randomised plus directed bench for unary_stream_decoder (BIT_WIDTH=4, W=8, LANES=2)
// with a frame-level reference model feeding a scoreboard queue.
module tb_unary_stream_decoder;

    localparam int W = 8;

    typedef struct packed {
        logic [1:0] ovf;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    unary_stream_decoder_if #(.LANES(2), .BIT_WIDTH(4)) bus ();

    unary_stream_decoder #(.BIT_WIDTH(4), .SIZE(3), .LANES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t last_obs;

    // Reference model: frame-level view of the decoder.
    bit         m_acc;
    bit         m_pending;
    int         m_n;
    int         m_cnt[2];
    logic [1:0] m_sign;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model_result();
        exp_t e;
        int   mag;
        int   v;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            mag = (m_cnt[i] >= W) ? W - 1 : m_cnt[i];
            v   = m_sign[i] ? -mag : mag;
            e.data[i*4 +: 4] = 4'(v);
            e.ovf[i] = (m_cnt[i] == W);
        end
        return e;
    endfunction

    // One clock: drive inputs, step the model at the edge, check outputs #1 after it.
    task automatic step(input logic fs, input logic [1:0] u, input logic [1:0] s, input logic r);
        logic acc_ok;
        logic drop;
        bus.frame_start = fs;
        bus.unary_in    = u;
        bus.sign_in     = s;
        bus.out_ready   = r;
        acc_ok = fs && !m_acc && (!m_pending || r);
        drop   = fs && !acc_ok;
        @(posedge clk);
        if (m_pending && r) m_pending = 1'b0;
        if (m_acc) begin
            for (int i = 0; i < 2; i++) m_cnt[i] += int'(u[i]);
            m_n++;
            if (m_n == W) begin
                exp_q.push_back(model_result());
                m_acc     = 1'b0;
                m_pending = 1'b1;
            end
        end
        if (acc_ok) begin
            m_acc  = 1'b1;
            m_n    = 1;
            m_sign = s;
            for (int i = 0; i < 2; i++) m_cnt[i] = int'(u[i]);
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_pending));
        check("frame_drop", 32'(bus.frame_drop), 32'(drop));
    endtask

    task automatic send_frame(input logic [7:0] l0, input logic [7:0] l1,
                              input logic [1:0] s, input logic r);
        for (int i = 0; i < W; i++) step(i == 0, {l1[i], l0[i]}, s, r);
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) step(1'b0, 2'($urandom), 2'($urandom), r);
    endtask

    task automatic expect_last(input string name, input logic [7:0] data, input logic [1:0] ovf);
        check(name, 32'(last_obs), 32'({ovf, data}));
        last_obs = '1;
    endtask

    task automatic do_reset();
        bus.frame_start = 1'b0;
        bus.unary_in    = '0;
        bus.sign_in     = '0;
        bus.out_ready   = 1'b0;
        reset = 1'b1;
        m_acc     = 1'b0;
        m_pending = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        check("reset_frame_drop", 32'(bus.frame_drop), 32'd0);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: handshakes and hold-stability, sampled on the falling edge.
    bit         prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_ovf;

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'({bus.overflow, bus.out_data}), 32'({prev_ovf, prev_data}));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got %0h, expected no result", bus.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_data", 32'(bus.out_data), 32'(e.data));
                    check("result_overflow", 32'(bus.overflow), 32'(e.ovf));
                end
                last_obs = {bus.overflow, bus.out_data};
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_ovf  = bus.overflow;
        end
    end

    initial begin
        last_obs = '1;
        do_reset();

        send_frame(8'h1F, 8'h03, 2'b00, 1'b1);
        idle(3, 1'b1);
        expect_last("basic", 8'h25, 2'b00);

        send_frame(8'h07, 8'h00, 2'b11, 1'b1);
        idle(3, 1'b1);
        expect_last("neg_zero", 8'h0D, 2'b00);

        send_frame(8'hFF, 8'h00, 2'b00, 1'b1);
        idle(3, 1'b1);
        expect_last("sat_pos", 8'h07, 2'b01);

        send_frame(8'hFF, 8'h00, 2'b01, 1'b1);
        idle(3, 1'b1);
        expect_last("sat_neg", 8'h09, 2'b01);

        send_frame(8'hAA, 8'h55, 2'b00, 1'b1);
        idle(3, 1'b1);
        expect_last("alternating", 8'h44, 2'b00);

        // Backpressure: six cycles with out_ready low, a rejected start, then back-to-back.
        send_frame(8'h0F, 8'h01, 2'b10, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 2'b11, 2'b00, 1'b0);
        idle(2, 1'b0);
        send_frame(8'h03, 8'h3F, 2'b00, 1'b1);
        expect_last("backpressure", 8'hF4, 2'b00);
        idle(3, 1'b1);
        expect_last("back_to_back", 8'h62, 2'b00);

        // Frame start during ACCUM is dropped.
        step(1'b1, 2'b01, 2'b00, 1'b1);
        step(1'b0, 2'b01, 2'b00, 1'b1);
        step(1'b1, 2'b01, 2'b00, 1'b1);
        idle(8, 1'b1);

        // Reset partway through a frame, then a fresh frame.
        for (int i = 0; i < 4; i++) step(i == 0, 2'b11, 2'b00, 1'b1);
        do_reset();
        idle(10, 1'b1);
        send_frame(8'hC3, 8'h80, 2'b01, 1'b1);
        idle(3, 1'b1);
        expect_last("after_reset", 8'h1C, 2'b00);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 5) == 0, 2'($urandom), 2'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !m_pending && !m_acc) break;
            step(1'b0, 2'b00, 2'b00, 1'b1);
        end
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
